// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the alu_exec execution stage.
//   alu_op_e    - 4-bit operation code from the mode selector (0..9 defined)
//   state_e     - control FSM states
//   alu_flags_t - N/Z/C/V flag bundle
package alu_pkg;

  localparam int unsigned MODE_W = 4;

  typedef enum logic [MODE_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_DIV = 4'd8,
    OP_MOD = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  // True for the two codes served by the sequential divider.
  function automatic logic is_div_op(input logic [MODE_W-1:0] m);
    return (m == OP_DIV) || (m == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_div_seq.sv
// alu_div_seq: unsigned restoring divider, one quotient bit per clock.
//   clk, rst            - clock, async active-high reset
//   start               - load dividend/divisor and begin N iterations
//   dividend, divisor   - N-bit unsigned operands (divisor must be nonzero)
//   done                - one-cycle pulse once quotient/remainder are final
//   quotient, remainder - N-bit results, held until the next start
module alu_div_seq #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam int unsigned CW = $clog2(N + 1);

  logic          running;
  logic [CW-1:0] count;
  logic [N-1:0]  dsr;
  logic [N:0]    trial_c;
  logic [N:0]    diff_c;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    trial_c = {remainder, quotient[N-1]};
    diff_c  = trial_c - {1'b0, dsr};
  end

  // quotient doubles as the dividend shift register; a negative diff restores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running   <= 1'b0;
      count     <= '0;
      dsr       <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running   <= 1'b1;
        count     <= '0;
        dsr       <= divisor;
        quotient  <= dividend;
        remainder <= '0;
      end else if (running) begin
        if (diff_c[N]) begin
          remainder <= trial_c[N-1:0];
          quotient  <= {quotient[N-2:0], 1'b0};
        end else begin
          remainder <= diff_c[N-1:0];
          quotient  <= {quotient[N-2:0], 1'b1};
        end
        count <= count + CW'(1);
        if (count == CW'(N - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execution stage behind the mode selector. Registered result and
// N/Z/C/V flags; single-cycle ops finish one cycle after accept, div/mod use
// alu_div_seq and finish N+1 cycles after accept.
//   clk, rst        - clock, async active-high reset
//   mode, a, b      - op code and N-bit operands, latched on start && ready
//   start           - request
//   ready, busy     - idle / operation in progress
//   done            - one-cycle pulse, result and flags valid
//   result          - N-bit result, held until the next completion
//   flag_n/z/c/v    - sign, zero, carry/borrow/shift-out/mul-overflow,
//                     signed overflow or divide-by-zero
// Build option: define ALU_SATURATE_EN to saturate add (to all ones on carry)
// and sub (to zero on borrow); flags still come from the wrapped operation.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         start,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v
);

  localparam int unsigned PW = 2 * N;
  localparam logic [N-1:0] SH_LIM = N'(N);

  state_e     state, state_d;
  alu_op_e    op_q, op_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, result_d;
  alu_flags_t flags_q, flags_d, exec_flags_c;
  logic [N-1:0] exec_res_c;
  logic         done_d, accept_c, div_start_c, div_done;
  logic [N-1:0] div_quot, div_rem;

  logic [N:0]    sum_c, dif_c, shl_c, shr_c;
  logic [PW-1:0] prod_c;
  logic          carry_c, ovf_c;

  alu_div_seq #(.N(N)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_c),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // Single-cycle datapath on the latched operands.
  always_comb begin
    sum_c  = {1'b0, a_q} + {1'b0, b_q};
    dif_c  = {1'b0, a_q} - {1'b0, b_q};
    prod_c = PW'(a_q) * PW'(b_q);
    // Extra bit on each shift captures the last bit shifted out.
    shl_c  = {1'b0, a_q} << b_q;
    shr_c  = {a_q, 1'b0} >> b_q;
    exec_res_c = '0;
    carry_c    = 1'b0;
    ovf_c      = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_res_c = sum_c[N-1:0];
        carry_c    = sum_c[N];
        ovf_c      = (a_q[N-1] == b_q[N-1]) && (sum_c[N-1] != a_q[N-1]);
`ifdef ALU_SATURATE_EN
        if (sum_c[N]) exec_res_c = '1;
`endif
      end
      OP_SUB: begin
        exec_res_c = dif_c[N-1:0];
        carry_c    = dif_c[N];
        ovf_c      = (a_q[N-1] != b_q[N-1]) && (dif_c[N-1] != a_q[N-1]);
`ifdef ALU_SATURATE_EN
        if (dif_c[N]) exec_res_c = '0;
`endif
      end
      OP_AND: exec_res_c = a_q & b_q;
      OP_OR:  exec_res_c = a_q | b_q;
      OP_XOR: exec_res_c = a_q ^ b_q;
      OP_SHL: if (b_q < SH_LIM) begin
        exec_res_c = shl_c[N-1:0];
        carry_c    = shl_c[N];
      end
      OP_SHR: if (b_q < SH_LIM) begin
        exec_res_c = shr_c[N:1];
        carry_c    = shr_c[0];
      end
      OP_MUL: begin
        exec_res_c = prod_c[N-1:0];
        carry_c    = |prod_c[PW-1:N];
      end
      // Only reached on divide-by-zero; nonzero divisors go through DIV.
      OP_DIV, OP_MOD: begin
        exec_res_c = '1;
        ovf_c      = 1'b1;
      end
      default: exec_res_c = '0;
    endcase
    exec_flags_c.n = exec_res_c[N-1];
    exec_flags_c.z = (exec_res_c == '0);
    exec_flags_c.c = carry_c;
    exec_flags_c.v = ovf_c;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result;
    flags_d     = flags_q;
    done_d      = 1'b0;
    div_start_c = 1'b0;
    accept_c    = start && ready;
    case (state)
      IDLE: if (accept_c) begin
        op_d = alu_op_e'(mode);
        a_d  = a;
        b_d  = b;
        if (is_div_op(mode) && (b != '0)) begin
          div_start_c = 1'b1;
          state_d     = DIV;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = exec_res_c;
        flags_d  = exec_flags_c;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      DIV: if (div_done) begin
        result_d  = (op_q == OP_MOD) ? div_rem : div_quot;
        flags_d   = '0;
        flags_d.n = result_d[N-1];
        flags_d.z = (result_d == '0);
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      result  <= '0;
      flags_q <= '0;
      done    <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      result  <= result_d;
      flags_q <= flags_d;
      done    <= done_d;
      ready   <= (state_d == IDLE);
      busy    <= (state_d != IDLE);
    end
  end

  assign flag_n = flags_q.n;
  assign flag_z = flags_q.z;
  assign flag_c = flags_q.c;
  assign flag_v = flags_q.v;

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution stage directly downstream of the mode selector. It consumes the 4-bit mode code (0–9) and two N-bit operands, and produces a registered result plus N/Z/C/V flags.
- Single-cycle ops finish in 1 cycle. Divide and modulo run on a sequential restoring divider.
- Output feeds the result 7-segment decoders and the flag LEDs.

Parameters:
- N, 4, operand/result width in bits (N >= 2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  4  operation code from mode selector
- a  input  N  operand A (unsigned; two's complement for V)
- b  input  N  operand B
- start  input  1  request; accepted when start && ready
- ready  output  1  block idle, can accept
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result/flags valid
- result  output  N  registered result, held until next accept
- flag_n  output  1  result[N-1]
- flag_z  output  1  result == 0
- flag_c  output  1  carry/borrow/shift-out/mul-overflow
- flag_v  output  1  signed overflow or divide-by-zero

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock. Reset forces state=IDLE, ready=1, busy=0, done=0, result=0, all flags 0.
- FSM states:
  - IDLE: ready=1. On accept, latch mode/a/b. Go to DIV if mode is 8/9 and b!=0; otherwise go to EXEC.
  - EXEC: compute, register result+flags, done=1, go to IDLE.
  - DIV: N iterations, one quotient bit per cycle. After the Nth iteration, register result, done=1, go to IDLE.
- Latency:
  - Accept at edge k. Single-cycle ops: done high in cycle k+1.
  - Div/mod: done high in cycle k+N+1.
  - ready is low from k+1 until the cycle after done.
- Mode map:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor
  - 5 shl by b, 6 logical shr by b
  - 7 mul (low N bits), 8 div quotient, 9 mod remainder
  - 10–15 invalid: result=0, flags all 0 except Z=1, done still pulses after 1 cycle.
- Flags:
  - add: C = carry-out of N+1-bit sum; V = signed overflow.
  - sub (a-b): C = borrow (a<b); V = signed overflow.
  - shl: C = last bit shifted out. shr: C = last bit shifted out.
  - Shift amount >= N: result=0, C=0.
  - mul: C = high N bits of the 2N-bit product nonzero.
  - Logic ops and div/mod: C=0, V=0.
- Divide-by-zero (mode 8/9, b==0): no DIV state. 1-cycle completion, result = all ones, V=1.
- start while busy: ignored, no queuing. Operand/mode changes after accept have no effect.
- done is a single cycle even if start stays high. Back-to-back accept is allowed in the cycle after done, since ready is 1 in IDLE.
- Reset mid-DIV: abort immediately, no done pulse, outputs go to reset values.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined: add overflow (C=1) forces result to all ones; sub borrow forces result to 0. Flags are computed from the unsaturated operation; Z/N reflect the saturated result.
- Undefined: add/sub wrap modulo 2^N.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e (OP_ADD=0 … OP_MOD=9)
  - typedef enum state_e {IDLE, EXEC, DIV}
  - typedef struct packed alu_flags_t {n, z, c, v}
- One sub-module: alu_div_seq.
  - Restoring divider with start/done handshake and N-cycle iteration.
  - Outputs quotient and remainder.
  - Instantiated once; alu_exec selects quotient or remainder.

Test Plan:
- N=4, mode=0, a=9, b=8 -> done at k+1, result=1, C=1, V=1, Z=0. With ALU_SATURATE_EN: result=15.
- mode=1, a=3, b=5 -> result=14, N=1, C=1, V=0. With ALU_SATURATE_EN: result=0, Z=1.
- mode=8, a=13, b=3 -> done at k+5, result=4; mode=9 same operands -> result=1. start pulsed at k+2 is ignored; ready=0 throughout.
- mode=8, a=7, b=0 -> done at k+1, result=15, V=1.
- Shifts and mul:
  - mode=5, a=4'b1011, b=1 -> result=4'b0110, C=1.
  - mode=6, b=4 -> result=0.
  - mode=7, a=5, b=4 -> result=4, C=1.
- Reset mid-operation: mode=9 accepted, rst asserted at k+2 -> immediately result=0, flags 0, ready=1, no done. mode=12 after release -> result=0, Z=1, done at k+1.
